// File: rtl/demod_rr_arbiter.sv
// demod_rr_arbiter
// Round-robin scheduler that lets NUM_CH IQ AXI-Stream channels share one
// conjugate-multiply FM demod datapath. Every forwarded beat carries its
// source channel in m00_axis_tid so the demod can keep per-channel history.
// A grant is held for a whole burst and released on tlast or after MAX_BURST
// beats; each new grant costs one idle bubble cycle.
module demod_rr_arbiter #(
    parameter int NUM_CH                 = 4,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int MAX_BURST              = 64
) (
    input  logic                                       s00_axis_aclk,
    input  logic                                       s00_axis_aresetn,
    input  logic [NUM_CH-1:0]                          ch_enable,
    input  logic [NUM_CH-1:0]                          s00_axis_tvalid,
    input  logic [NUM_CH-1:0]                          s00_axis_tlast,
    input  logic [NUM_CH*C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [NUM_CH*(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    output logic [NUM_CH-1:0]                          s00_axis_tready,
    input  logic                                       m00_axis_tready,
    output logic                                       m00_axis_tvalid,
    output logic                                       m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]          m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]        m00_axis_tstrb,
    output logic [$clog2(NUM_CH)-1:0]                  m00_axis_tid,
    output logic                                       busy
);

    localparam int DW = C_S00_AXIS_TDATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int CW = $clog2(NUM_CH);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Arbitration state
    state_t          state_q, state_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   gnt_q, gnt_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    // Output register stage
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic [SW-1:0]   tstrb_q, tstrb_d;
    logic [CW-1:0]   tid_q, tid_d;

    // Request search and granted-channel view
    logic [NUM_CH-1:0] req;
    logic              pick_found;
    logic [CW-1:0]     pick_idx;
    int                ptr_int;
    int                cur_dist;
    int                best_dist;

    logic              sel_valid;
    logic              sel_last;
    logic [DW-1:0]     sel_data;
    logic [SW-1:0]     sel_strb;

    logic              stage_ready;
    logic              xfer;
    logic              burst_done;
    logic [CW-1:0]     gnt_next;

    assign req         = s00_axis_tvalid & ch_enable;
    assign ptr_int     = int'(rr_ptr_q);
    assign stage_ready = m00_axis_tready | ~tvalid_q;
    assign xfer        = (state_q == ST_GRANT) & sel_valid & stage_ready;
    assign burst_done  = xfer & (sel_last | (beat_cnt_q == BW'(MAX_BURST - 1)));
    assign gnt_next    = (gnt_q == CW'(NUM_CH - 1)) ? '0 : gnt_q + CW'(1);

    // Round-robin pick: the requesting channel closest to rr_ptr (wrapping) wins
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        best_dist  = NUM_CH;
        cur_dist   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (req[k]) begin
                cur_dist = (k >= ptr_int) ? (k - ptr_int) : (k + NUM_CH - ptr_int);
                if (cur_dist < best_dist) begin
                    best_dist  = cur_dist;
                    pick_idx   = CW'(k);
                    pick_found = 1'b1;
                end
            end
        end
    end

    // Multiplex the currently granted channel's stream signals
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_q == CW'(k)) begin
                sel_valid = s00_axis_tvalid[k];
                sel_last  = s00_axis_tlast[k];
                sel_data  = s00_axis_tdata[k*DW +: DW];
                sel_strb  = s00_axis_tstrb[k*SW +: SW];
            end
        end
    end

    // Only the granted channel sees ready, and only while the output stage can accept
    always_comb begin
        s00_axis_tready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s00_axis_tready[k] = (state_q == ST_GRANT) && (gnt_q == CW'(k)) && stage_ready;
        end
    end

    // Next-state logic: pick a channel in IDLE, count beats and release in GRANT
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                if (burst_done) begin
                    beat_cnt_d = '0;
                    rr_ptr_d   = gnt_next;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: load on a transfer, drain when downstream accepts, otherwise hold
    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tid_d    = tid_q;
        if (xfer) begin
            tvalid_d = 1'b1;
            tlast_d  = sel_last;
            tdata_d  = sel_data;
            tstrb_d  = sel_strb;
            tid_d    = gnt_q;
        end else if (m00_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            tstrb_q    <= '0;
            tid_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            tstrb_q    <= tstrb_d;
            tid_q      <= tid_d;
        end
    end

    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tdata  = tdata_q;
    assign m00_axis_tstrb  = tstrb_q;
    assign m00_axis_tid    = tid_q;
    assign busy            = (state_q == ST_GRANT);

endmodule
